// File: rtl/pipe_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_scoreboard_pkg
// Description : Shared forward-select encodings and default parameter values
//               for the pipeline register scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_scoreboard_pkg;

  // Operand source encodings seen by the EXE operand muxes
  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,   // register file (no forwarding)
    FWD_EXMEM = 2'd1,   // EXE/MEM pipeline register
    FWD_MEMWB = 2'd2    // MEM/WB pipeline register
  } fwd_sel_e;

  localparam int DEF_NREGS      = 32;
  localparam int DEF_PIPE_DEPTH = 3;
  localparam int DEF_FWD_EN     = 1;
  localparam int DEF_CW         = 16;

endpackage : pipe_scoreboard_pkg
`default_nettype wire

// File: rtl/pipe_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_scoreboard_if
// Description : ID-stage request / hazard response bundle between the
//               decode pipeline (master) and the scoreboard (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_scoreboard_if
  import pipe_scoreboard_pkg::*;
#(
  parameter int NREGS      = DEF_NREGS,
  parameter int PIPE_DEPTH = DEF_PIPE_DEPTH,
  parameter int CW         = DEF_CW
);
  localparam int AW = $clog2(NREGS);
  localparam int SW = $clog2(PIPE_DEPTH + 1);

  logic          id_valid;
  logic [AW-1:0] id_rs;
  logic [AW-1:0] id_rt;
  logic          id_rs_used;
  logic          id_rt_used;
  logic [AW-1:0] id_dst;
  logic          id_wr;
  logic [SW-1:0] id_lat;
  logic          flush;
  logic          id_stall;
  logic [SW-1:0] ex_fwd_rs_sel;
  logic [SW-1:0] ex_fwd_rt_sel;
  logic [CW-1:0] perf_stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
    output id_dst, id_wr, id_lat, flush,
    input  id_stall, ex_fwd_rs_sel, ex_fwd_rt_sel, perf_stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
    input  id_dst, id_wr, id_lat, flush,
    output id_stall, ex_fwd_rs_sel, ex_fwd_rt_sel, perf_stall_cnt
  );

endinterface : pipe_scoreboard_if
`default_nettype wire

// File: rtl/pipe_scoreboard_entry.sv
`default_nettype none
// ============================================================================
// Module      : pipe_scoreboard_entry
// Description : Pending-writer tracker for one architectural register: an age
//               counter since issue plus the producer's forwarding latency.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_scoreboard_entry
  import pipe_scoreboard_pkg::*;
#(
  parameter int PIPE_DEPTH = DEF_PIPE_DEPTH,
  parameter int FWD_EN     = DEF_FWD_EN,
  parameter int SW         = $clog2(DEF_PIPE_DEPTH + 1)
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          i_alloc,
  input  wire logic [SW-1:0] i_lat,
  output logic      [SW-1:0] o_age,
  output logic               o_ready
);

  localparam logic [SW-1:0] c_depth = SW'(PIPE_DEPTH);

  logic [SW-1:0] r_age;
  logic [SW-1:0] r_lat;

  // Age advances every cycle until writeback; a new producer restarts it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_age <= '0;
      r_lat <= '0;
    end else if (i_alloc) begin
      r_age <= SW'(1);
      r_lat <= i_lat;
    end else if (r_age == c_depth) begin
      r_age <= '0;
    end else if (r_age != '0) begin
      r_age <= r_age + SW'(1);
    end
  end

  // Ready when idle, in writeback (write-through RF), or forwardable
  always_comb begin
    o_ready = (r_age == '0) || (r_age == c_depth);
    if (FWD_EN != 0 && r_age >= r_lat) begin
      o_ready = 1'b1;
    end
  end

  assign o_age = r_age;

endmodule : pipe_scoreboard_entry
`default_nettype wire

// File: rtl/pipe_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : pipe_scoreboard
// Description : Register scoreboard for an in-order pipeline. Detects RAW
//               hazards at ID, stalls or selects the forwarding source for
//               EXE, and counts stall cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_scoreboard
  import pipe_scoreboard_pkg::*;
#(
  parameter int NREGS      = DEF_NREGS,
  parameter int PIPE_DEPTH = DEF_PIPE_DEPTH,
  parameter int FWD_EN     = DEF_FWD_EN,
  parameter int CW         = DEF_CW
) (
  input  wire logic          clk,
  input  wire logic          rst,
  pipe_scoreboard_if.slave   bus
);

  localparam int SW = $clog2(PIPE_DEPTH + 1);
  localparam logic [SW-1:0] c_depth = SW'(PIPE_DEPTH);

  logic [SW-1:0]    w_age [NREGS];
  logic [NREGS-1:0] w_ready;
  logic             w_rs_ready;
  logic             w_rt_ready;
  logic             w_hazard;
  logic             w_stall;
  logic             w_issue;
  logic [SW-1:0]    w_rs_sel;
  logic [SW-1:0]    w_rt_sel;
  logic [SW-1:0]    r_rs_sel;
  logic [SW-1:0]    r_rt_sel;
  logic [CW-1:0]    r_stall_cnt;

  // Register 0 never has a pending writer
  assign w_age[0]   = '0;
  assign w_ready[0] = 1'b1;

  for (genvar r = 1; r < NREGS; r++) begin : g_entry
    logic w_alloc;
    assign w_alloc = w_issue & bus.id_wr & (bus.id_dst == r[$bits(bus.id_dst)-1:0]);

    pipe_scoreboard_entry #(
      .PIPE_DEPTH (PIPE_DEPTH),
      .FWD_EN     (FWD_EN),
      .SW         (SW)
    ) u_entry (
      .clk     (clk),
      .rst     (rst),
      .i_alloc (w_alloc),
      .i_lat   (bus.id_lat),
      .o_age   (w_age[r]),
      .o_ready (w_ready[r])
    );
  end

  // Forward only while the producer sits in EXE/MEM .. last pre-WB stage
  function automatic logic [SW-1:0] f_fwd_sel(input logic used, input logic nonzero,
                                               input logic [SW-1:0] age);
    f_fwd_sel = SW'(FWD_RF);
    if (FWD_EN != 0 && used && nonzero && age >= SW'(1) && age <= c_depth - SW'(1)) begin
      f_fwd_sel = age;
    end
  endfunction

  // Hazard detection, stall/issue decision and next forward selects
  always_comb begin
    w_rs_ready = (bus.id_rs == '0) | w_ready[bus.id_rs];
    w_rt_ready = (bus.id_rt == '0) | w_ready[bus.id_rt];
    w_hazard   = (bus.id_rs_used & ~w_rs_ready) | (bus.id_rt_used & ~w_rt_ready);
    w_stall    = ~rst & bus.id_valid & ~bus.flush &  w_hazard;
    w_issue    = ~rst & bus.id_valid & ~bus.flush & ~w_hazard;
    w_rs_sel   = f_fwd_sel(bus.id_rs_used, bus.id_rs != '0, w_age[bus.id_rs]);
    w_rt_sel   = f_fwd_sel(bus.id_rt_used, bus.id_rt != '0, w_age[bus.id_rt]);
  end

  // EXE operand selects; a bubble enters EXE whenever nothing issues
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rs_sel <= SW'(FWD_RF);
      r_rt_sel <= SW'(FWD_RF);
    end else if (w_issue) begin
      r_rs_sel <= w_rs_sel;
      r_rt_sel <= w_rt_sel;
    end else begin
      r_rs_sel <= SW'(FWD_RF);
      r_rt_sel <= SW'(FWD_RF);
    end
  end

  // Saturating stall-cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && r_stall_cnt != '1) begin
      r_stall_cnt <= r_stall_cnt + CW'(1);
    end
  end

  assign bus.id_stall       = w_stall;
  assign bus.ex_fwd_rs_sel  = r_rs_sel;
  assign bus.ex_fwd_rt_sel  = r_rt_sel;
  assign bus.perf_stall_cnt = r_stall_cnt;

endmodule : pipe_scoreboard
`default_nettype wire

// File: tb/tb_pipe_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_scoreboard
// Description : Directed self-checking bench. DUT A uses forwarding with a
//               16-bit counter, DUT B is stall-only with a 2-bit counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_scoreboard;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  typedef struct packed {
    logic [1:0] rs;
    logic [1:0] rt;
  } exp_sel_t;

  exp_sel_t q_exp[$];

  pipe_scoreboard_if #(.NREGS(32), .PIPE_DEPTH(3), .CW(16)) ifa ();
  pipe_scoreboard_if #(.NREGS(32), .PIPE_DEPTH(3), .CW(2))  ifb ();

  pipe_scoreboard #(.NREGS(32), .PIPE_DEPTH(3), .FWD_EN(1), .CW(16)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  pipe_scoreboard #(.NREGS(32), .PIPE_DEPTH(3), .FWD_EN(0), .CW(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired observed running required finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One ID cycle on DUT A (b=0) or DUT B (b=1); the other DUT sees a bubble.
  task automatic step(input bit b, input bit v,
                      input logic [4:0] rs, input bit rsu,
                      input logic [4:0] rt, input bit rtu,
                      input logic [4:0] dst, input bit wr, input logic [1:0] lat,
                      input bit fl, input bit exp_stall,
                      input logic [1:0] exp_rs, input logic [1:0] exp_rt);
    exp_sel_t e;
    ifa.id_valid = v & ~b;  ifb.id_valid = v & b;
    ifa.flush    = fl & ~b; ifb.flush    = fl & b;
    ifa.id_rs = rs; ifa.id_rs_used = rsu; ifa.id_rt = rt; ifa.id_rt_used = rtu;
    ifb.id_rs = rs; ifb.id_rs_used = rsu; ifb.id_rt = rt; ifb.id_rt_used = rtu;
    ifa.id_dst = dst; ifa.id_wr = wr; ifa.id_lat = lat;
    ifb.id_dst = dst; ifb.id_wr = wr; ifb.id_lat = lat;
    @(negedge clk);
    chk(b ? "b_stall" : "a_stall", b ? ifb.id_stall : ifa.id_stall, 32'(exp_stall));
    q_exp.push_back('{rs: exp_rs, rt: exp_rt});
    @(posedge clk);
    #1;
    if (q_exp.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = q_exp.pop_front();
      chk(b ? "b_rs_sel" : "a_rs_sel", b ? ifb.ex_fwd_rs_sel : ifa.ex_fwd_rs_sel, 32'(e.rs));
      chk(b ? "b_rt_sel" : "a_rt_sel", b ? ifb.ex_fwd_rt_sel : ifa.ex_fwd_rt_sel, 32'(e.rt));
    end
  endtask

  task automatic idle(input bit b);
    step(b, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd1, 1'b0, 1'b0, 2'd0, 2'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    ifa.id_valid = 1'b1; ifa.id_rs = 5'd3; ifa.id_rs_used = 1'b1;
    ifa.id_rt = 5'd4; ifa.id_rt_used = 1'b1; ifa.id_dst = 5'd3; ifa.id_wr = 1'b1;
    ifa.id_lat = 2'd1; ifa.flush = 1'b0;
    ifb.id_valid = 1'b0; ifb.id_rs = '0; ifb.id_rs_used = 1'b0; ifb.id_rt = '0;
    ifb.id_rt_used = 1'b0; ifb.id_dst = '0; ifb.id_wr = 1'b0; ifb.id_lat = 2'd1;
    ifb.flush = 1'b0;

    // Reset state
    #3;
    chk("rst_a_stall", ifa.id_stall, 0);
    chk("rst_a_rs_sel", ifa.ex_fwd_rs_sel, 0);
    chk("rst_a_rt_sel", ifa.ex_fwd_rt_sel, 0);
    chk("rst_a_cnt", ifa.perf_stall_cnt, 0);
    chk("rst_b_cnt", ifb.perf_stall_cnt, 0);
    @(posedge clk); @(posedge clk);
    #2 rst = 1'b0;
    idle(0);

    // ALU producer r8 lat 1, consumer rs=r8 forwards from EXE/MEM
    step(0, 1, 5'd0, 0, 5'd0, 0, 5'd8, 1, 2'd1, 0, 0, 2'd0, 2'd0);
    step(0, 1, 5'd8, 1, 5'd0, 0, 5'd0, 0, 2'd1, 0, 0, 2'd1, 2'd0);

    // Load r9 lat 2, consumer rt=r9: one stall then MEM/WB forward
    step(0, 1, 5'd0, 0, 5'd0, 0, 5'd9, 1, 2'd2, 0, 0, 2'd0, 2'd0);
    step(0, 1, 5'd0, 0, 5'd9, 1, 5'd0, 0, 2'd1, 0, 1, 2'd0, 2'd0);
    step(0, 1, 5'd0, 0, 5'd9, 1, 5'd0, 0, 2'd1, 0, 0, 2'd0, 2'd2);
    chk("a_cnt_loaduse", ifa.perf_stall_cnt, 1);

    // Distance 3: producer r10, two unrelated, consumer reads the RF
    step(0, 1, 5'd0, 0, 5'd0, 0, 5'd10, 1, 2'd1, 0, 0, 2'd0, 2'd0);
    step(0, 1, 5'd1, 1, 5'd2, 1, 5'd0, 0, 2'd1, 0, 0, 2'd0, 2'd0);
    step(0, 1, 5'd3, 1, 5'd4, 1, 5'd0, 0, 2'd1, 0, 0, 2'd0, 2'd0);
    step(0, 1, 5'd10, 1, 5'd10, 1, 5'd0, 0, 2'd1, 0, 0, 2'd0, 2'd0);

    // Flush during a load-use hazard: no stall, no count, bubble
    step(0, 1, 5'd0, 0, 5'd0, 0, 5'd11, 1, 2'd2, 0, 0, 2'd0, 2'd0);
    step(0, 1, 5'd11, 1, 5'd0, 0, 5'd0, 0, 2'd1, 1, 0, 2'd0, 2'd0);
    chk("a_cnt_flush", ifa.perf_stall_cnt, 1);

    // Newest producer wins: lat 2 then lat 1 to r12, consumer forwards at 1
    step(0, 1, 5'd0, 0, 5'd0, 0, 5'd12, 1, 2'd2, 0, 0, 2'd0, 2'd0);
    step(0, 1, 5'd0, 0, 5'd0, 0, 5'd12, 1, 2'd1, 0, 0, 2'd0, 2'd0);
    step(0, 1, 5'd12, 1, 5'd0, 0, 5'd0, 0, 2'd1, 0, 0, 2'd1, 2'd0);

    // Write r0 then read r0: no pending entry, no stall, sel 0
    step(0, 1, 5'd0, 0, 5'd0, 0, 5'd0, 1, 2'd2, 0, 0, 2'd0, 2'd0);
    step(0, 1, 5'd0, 1, 5'd0, 1, 5'd0, 0, 2'd1, 0, 0, 2'd0, 2'd0);

    // Reset asserted mid-hazard drops the pending load on r13
    step(0, 1, 5'd0, 0, 5'd0, 0, 5'd13, 1, 2'd2, 0, 0, 2'd0, 2'd0);
    ifa.id_rs_used = 1'b0; ifa.id_rt = 5'd13; ifa.id_rt_used = 1'b1; ifa.id_wr = 1'b0;
    @(negedge clk);
    chk("a_midrst_pre_stall", ifa.id_stall, 1);
    rst = 1'b1;
    #1;
    chk("a_midrst_stall", ifa.id_stall, 0);
    chk("a_midrst_cnt", ifa.perf_stall_cnt, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    step(0, 1, 5'd0, 0, 5'd13, 1, 5'd0, 0, 2'd1, 0, 0, 2'd0, 2'd0);
    chk("a_cnt_postrst", ifa.perf_stall_cnt, 0);

    // Stall-only DUT: ALU producer r8 then consumer stalls twice, sel 0
    step(1, 1, 5'd0, 0, 5'd0, 0, 5'd8, 1, 2'd1, 0, 0, 2'd0, 2'd0);
    step(1, 1, 5'd8, 1, 5'd0, 0, 5'd0, 0, 2'd1, 0, 1, 2'd0, 2'd0);
    step(1, 1, 5'd8, 1, 5'd0, 0, 5'd0, 0, 2'd1, 0, 1, 2'd0, 2'd0);
    step(1, 1, 5'd8, 1, 5'd0, 0, 5'd0, 0, 2'd1, 0, 0, 2'd0, 2'd0);
    chk("b_cnt_two", ifb.perf_stall_cnt, 2);

    // Second pair would reach 4 stalls; the 2-bit counter holds at 3
    step(1, 1, 5'd0, 0, 5'd0, 0, 5'd8, 1, 2'd1, 0, 0, 2'd0, 2'd0);
    step(1, 1, 5'd0, 0, 5'd8, 1, 5'd0, 0, 2'd1, 0, 1, 2'd0, 2'd0);
    chk("b_cnt_three", ifb.perf_stall_cnt, 3);
    step(1, 1, 5'd0, 0, 5'd8, 1, 5'd0, 0, 2'd1, 0, 1, 2'd0, 2'd0);
    chk("b_cnt_sat", ifb.perf_stall_cnt, 3);
    step(1, 1, 5'd0, 0, 5'd8, 1, 5'd0, 0, 2'd1, 0, 0, 2'd0, 2'd0);
    chk("b_cnt_hold", ifb.perf_stall_cnt, 3);
    chk("a_cnt_untouched", ifa.perf_stall_cnt, 0);
    idle(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pipe_scoreboard
`default_nettype wire
